// File: rtl/zero_flag_gen.sv
// zero_flag_gen: flags zero activations of a fixed-length row and counts them per row
module zero_flag_gen #(
  parameter int DATA_W  = 16,
  parameter int ROW_LEN = 12,
  parameter int CNT_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stall,
  input  logic              iact_valid,
  input  logic [DATA_W-1:0] iact_data,
  output logic              iact_ready,
  output logic              flag_out,
  output logic              fwd_valid,
  output logic [DATA_W-1:0] fwd_data,
  output logic              busy,
  output logic              row_done,
  output logic [CNT_W-1:0]  skip_count
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] elem_cnt_q, elem_cnt_d, zero_cnt_q, zero_cnt_d, skip_count_q, skip_count_d;
  logic [DATA_W-1:0] fwd_data_q, fwd_data_d;
  logic fwd_valid_q, fwd_valid_d, flag_q, flag_d, row_done_q, row_done_d;
  logic accept, is_zero, last, begin_row;
  assign iact_ready = (state_q == SCAN) && !stall;
  always_comb begin
    accept       = iact_valid && iact_ready;
    is_zero      = iact_data == '0;
    last         = accept && (elem_cnt_q == CNT_W'(ROW_LEN - 1));
    begin_row    = (state_q == IDLE) && start;
    state_d      = state_q == IDLE ? (start ? SCAN : IDLE) :
                   state_q == SCAN ? (last ? DONE : SCAN) : IDLE;
    elem_cnt_d   = begin_row ? '0 : accept ? elem_cnt_q + 1'b1 : elem_cnt_q;
    zero_cnt_d   = begin_row ? '0 : (accept && is_zero) ? zero_cnt_q + 1'b1 : zero_cnt_q;
    fwd_valid_d  = accept;
    flag_d       = accept && is_zero;
    fwd_data_d   = accept ? iact_data : fwd_data_q;
    row_done_d   = last;
    // the final element's zero is not yet in zero_cnt_q, so fold it in here
    skip_count_d = last ? zero_cnt_q + CNT_W'(is_zero) : skip_count_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      elem_cnt_q   <= '0;
      zero_cnt_q   <= '0;
      skip_count_q <= '0;
      fwd_data_q   <= '0;
      fwd_valid_q  <= 1'b0;
      flag_q       <= 1'b0;
      row_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      elem_cnt_q   <= elem_cnt_d;
      zero_cnt_q   <= zero_cnt_d;
      skip_count_q <= skip_count_d;
      fwd_data_q   <= fwd_data_d;
      fwd_valid_q  <= fwd_valid_d;
      flag_q       <= flag_d;
      row_done_q   <= row_done_d;
    end
  end
  assign flag_out   = flag_q;
  assign fwd_valid  = fwd_valid_q;
  assign fwd_data   = fwd_data_q;
  assign busy       = state_q != IDLE;
  assign row_done   = row_done_q;
  assign skip_count = skip_count_q;
endmodule

// File: tb/tb_zero_flag_gen.sv
// tb_zero_flag_gen: directed rows; driver queues expected outputs, negedge monitor checks them
module tb_zero_flag_gen;
  localparam int DW = 16;
  localparam int RL = 12;
  localparam int CW = 4;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, stall = 1'b0, iact_valid = 1'b0;
  logic [DW-1:0] iact_data = '0;
  logic iact_ready, flag_out, fwd_valid, busy, row_done;
  logic [DW-1:0] fwd_data;
  logic [CW-1:0] skip_count;
  typedef struct packed {int cy; logic f; logic [DW-1:0] d;} item_t;
  typedef struct packed {int cy; logic [CW-1:0] sk;} done_t;
  item_t q_item[$];
  done_t q_done[$];
  item_t it;
  done_t dn;
  int cyc = 0, errors = 0, checks = 0, rd_seen = 0, rd_exp = 0, ms = 0;
  logic [CW-1:0] mskip = '0, pend_skip = '0;
  logic [DW-1:0] row [RL];
  zero_flag_gen #(.DATA_W(DW), .ROW_LEN(RL), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall), .iact_valid(iact_valid),
    .iact_data(iact_data), .iact_ready(iact_ready), .flag_out(flag_out), .fwd_valid(fwd_valid),
    .fwd_data(fwd_data), .busy(busy), .row_done(row_done), .skip_count(skip_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask
  always @(negedge clk) begin
    chk("flag_without_valid", 32'(flag_out & ~fwd_valid), 0);
    if (fwd_valid === 1'b1) begin
      chk("fwd_expected", 32'(q_item.size() != 0), 1);
      if (q_item.size() != 0) begin
        it = q_item.pop_front();
        chk("fwd_cycle", cyc, it.cy);
        chk("flag_out", 32'(flag_out), 32'(it.f));
        chk("fwd_data", 32'(fwd_data), 32'(it.d));
      end
    end
    if (row_done === 1'b1) begin
      rd_seen++;
      chk("done_expected", 32'(q_done.size() != 0), 1);
      if (q_done.size() != 0) begin
        dn = q_done.pop_front();
        chk("row_done_cycle", cyc, dn.cy);
        chk("skip_count", 32'(skip_count), 32'(dn.sk));
      end
    end
  end
  // one cycle of stimulus; ms is the bench's own view of IDLE(0)/SCAN(1)/DONE(2)
  task automatic drive(input logic v, input logic [DW-1:0] d, input logic s, input logic st);
    @(negedge clk);
    iact_valid = v;
    iact_data = d;
    stall = s;
    start = st;
    #1;
    if (ms == 2) mskip = pend_skip;
    chk("iact_ready", 32'(iact_ready), 32'(ms == 1 && !s));
    chk("busy", 32'(busy), 32'(ms != 0));
    chk("skip_hold", 32'(skip_count), 32'(mskip));
    if (ms == 0) ms = st ? 1 : 0;
    else if (ms == 2) ms = 0;
    else if (v && !s) q_item.push_back('{cy: cyc + 1, f: d == '0, d: d});
  endtask
  task automatic feed_row(input logic [CW-1:0] exp_skip, input int stall_after, input bit toggle,
                          input int start_at, input bit done_start, input int abort_at);
    int k, c, stalls;
    bit v, s;
    k = 0; c = 0; stalls = 0;
    drive(1'b0, '0, 1'b0, 1'b1);
    while (k < RL) begin
      if (k == abort_at) begin
        @(negedge clk);
        rst = 1'b1; iact_valid = 1'b0; start = 1'b0; stall = 1'b0;
        ms = 0; mskip = '0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_fwd_valid", 32'(fwd_valid), 0);
        chk("abort_skip", 32'(skip_count), 0);
        chk("abort_row_done", 32'(row_done), 0);
        return;
      end
      v = !toggle || (c % 2 == 0);
      s = (k == stall_after) && (stalls < 3);
      if (s) stalls++;
      if (v && !s && k == RL - 1) begin
        q_done.push_back('{cy: cyc + 2, sk: exp_skip});
        pend_skip = exp_skip;
        rd_exp++;
      end
      drive(v, row[k], s, c == start_at);
      if (v && !s) k++;
      if (k == RL) ms = 2;
      c++;
    end
    drive(1'b0, '0, 1'b0, done_start);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(iact_ready), 0);
    chk("rst_flag", 32'(flag_out), 0);
    chk("rst_fwd_valid", 32'(fwd_valid), 0);
    chk("rst_fwd_data", 32'(fwd_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_row_done", 32'(row_done), 0);
    chk("rst_skip", 32'(skip_count), 0);
    rst = 1'b0;
    row = '{5, 0, 7, 0, 0, 1, 2, 0, 3, 4, 0, 9};
    feed_row(5, -1, 1'b0, -1, 1'b0, -1);
    drive(1'b0, '0, 1'b0, 1'b0);
    row = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    feed_row(12, -1, 1'b0, -1, 1'b0, -1);
    row = '{1, 2, 3, 0, 4, 5, 6, 0, 7, 8, 9, 0};
    feed_row(3, 4, 1'b0, -1, 1'b0, -1);
    row = '{0, 0, 3, 3, 0, 0, 3, 3, 0, 0, 3, 3};
    feed_row(6, -1, 1'b0, 5, 1'b1, -1);
    drive(1'b0, '0, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    row = '{5, 0, 7, 0, 0, 1, 2, 0, 3, 4, 0, 9};
    feed_row(5, -1, 1'b0, -1, 1'b0, 7);
    drive(1'b0, '0, 1'b0, 1'b0);
    row = '{8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    feed_row(10, -1, 1'b0, -1, 1'b0, -1);
    row = '{0, 16'hffff, 0, 1, 0, 16'h8000, 0, 2, 0, 3, 0, 4};
    feed_row(6, -1, 1'b1, -1, 1'b0, -1);
    repeat (3) drive(1'b0, '0, 1'b0, 1'b0);
    chk("items_drained", q_item.size(), 0);
    chk("dones_drained", q_done.size(), 0);
    chk("row_done_count", rd_seen, rd_exp);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
